pipe_stage_reg: RTL and testbench

Parametrised pipeline-stage register that generalises the fixed ID/EX latch to any number of equal-width fields. It adds a valid/ready handshake, an optional 2-entry skid buffer that registers the upstream ready path, synchronous flush, and bubble insertion. It sits between any two CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Hazard logic drives it through i_ready (stall) and i_flush (squash).

---
 rtl/pipe_stage_reg.sv | 163 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline-stage register with valid/ready handshake,
// optional 2-entry skid buffer, synchronous flush and bubble insertion.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_data       upstream fields, field k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_valid      upstream beat valid
//   o_ready      stage can accept a beat (registered when SKID=1)
//   o_data       head-entry fields; field CTRL_FIELD reads 0 while o_valid=0
//   o_valid      head entry valid
//   i_ready      downstream accepts the head (0 = stall)
//   i_flush      synchronous squash of all held and incoming beats
//   o_occupancy  number of valid entries (0..2)
module pipe_stage_reg #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_FIELDS = 7,
  parameter int unsigned CTRL_FIELD = 0,
  parameter int unsigned SKID       = 1
) (
  input  logic                             clk,
  input  logic                             i_rst_n,
  input  logic [NUM_FIELDS*DATA_WIDTH-1:0] i_data,
  input  logic                             i_valid,
  output logic                             o_ready,
  output logic [NUM_FIELDS*DATA_WIDTH-1:0] o_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  input  logic                             i_flush,
  output logic [1:0]                       o_occupancy
);

  localparam int unsigned BUS_W  = NUM_FIELDS * DATA_WIDTH;
  localparam int unsigned CTRL_LO = CTRL_FIELD * DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [BUS_W-1:0] main_q, skid_q;
  logic             push, pop;
  logic             load_main_in, load_main_skid, load_skid;

  assign push = i_valid && o_ready;
  assign pop  = o_valid && i_ready;

  // State register
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and data-load decisions; flush wins over everything
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (i_flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d      = ST_ONE;
            load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            load_main_in = 1'b1;
          end else if (push) begin
            state_d   = ST_TWO;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_d        = ST_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Outputs decoded from state; control field masked to zero during a bubble
  always_comb begin
    o_valid     = 1'b0;
    o_occupancy = 2'd0;
    case (state_q)
      ST_ONE: begin
        o_valid     = 1'b1;
        o_occupancy = 2'd1;
      end
      ST_TWO: begin
        o_valid     = 1'b1;
        o_occupancy = 2'd2;
      end
      default: begin
        o_valid     = 1'b0;
        o_occupancy = 2'd0;
      end
    endcase
    o_data = main_q;
    if (state_q == ST_EMPTY) begin
      o_data[CTRL_LO +: DATA_WIDTH] = '0;
    end
  end

  // Data registers only move on accepted pushes or skid-to-main transfers
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= i_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= i_data;
      end
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic ready_q;
      // Registered ready: resets low, so it also encodes the out-of-reset edge
      always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          ready_q <= 1'b0;
        end else begin
          ready_q <= (state_d != ST_TWO);
        end
      end
      assign o_ready = ready_q;
    end else begin : g_noskid
      logic oor_q;
      // Out-of-reset flag gates the combinational ready path
      always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          oor_q <= 1'b0;
        end else begin
          oor_q <= 1'b1;
        end
      end
      assign o_ready = oor_q && ((state_q == ST_EMPTY) || i_ready);
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 instance (a) and a SKID=0 instance (b),
// both with NUM_FIELDS=4 and CTRL_FIELD=2, checked against queue models.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned NF = 4;
  localparam int unsigned CF = 2;
  localparam int unsigned BW = NF * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [BW-1:0] data_a = '0, data_b = '0;
  logic          valid_a = 1'b0, valid_b = 1'b0;
  logic          rin_a = 1'b0, rin_b = 1'b0;
  logic          flush_a = 1'b0, flush_b = 1'b0;
  logic          ready_a, ready_b, ovalid_a, ovalid_b;
  logic [BW-1:0] odata_a, odata_b;
  logic [1:0]    occ_a, occ_b;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: FIFO contents, last head value, out-of-reset flag
  logic [BW-1:0] qa[$];
  logic [BW-1:0] qb[$];
  logic [BW-1:0] last_a, last_b;
  bit            m_oor;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_WIDTH(DW), .NUM_FIELDS(NF), .CTRL_FIELD(CF), .SKID(1)) dut_a (
    .clk(clk), .i_rst_n(rst_n), .i_data(data_a), .i_valid(valid_a), .o_ready(ready_a),
    .o_data(odata_a), .o_valid(ovalid_a), .i_ready(rin_a), .i_flush(flush_a),
    .o_occupancy(occ_a));

  pipe_stage_reg #(.DATA_WIDTH(DW), .NUM_FIELDS(NF), .CTRL_FIELD(CF), .SKID(0)) dut_b (
    .clk(clk), .i_rst_n(rst_n), .i_data(data_b), .i_valid(valid_b), .o_ready(ready_b),
    .o_data(odata_b), .o_valid(ovalid_b), .i_ready(rin_b), .i_flush(flush_b),
    .o_occupancy(occ_b));

  function automatic logic [BW-1:0] beat(input int n);
    logic [BW-1:0] r;
    r = '0;
    for (int k = 0; k < int'(NF); k++) r[k*DW +: DW] = DW'(32'h100 * n + k);
    return r;
  endfunction

  function automatic logic [BW-1:0] masked(input logic [BW-1:0] d, input bit empty);
    logic [BW-1:0] r;
    r = d;
    if (empty) r[CF*DW +: DW] = '0;
    return r;
  endfunction

  task automatic reset_model();
    qa.delete(); qb.delete();
    last_a = '0; last_b = '0;
    m_oor = 1'b0;
  endtask

  // One clock edge: model decides push/pop from pre-edge inputs, then advances
  task automatic tick();
    bit push_a, pop_a, push_b, pop_b;
    push_a = valid_a && m_oor && (qa.size() < 2);
    pop_a  = (qa.size() > 0) && rin_a;
    push_b = valid_b && m_oor && ((qb.size() == 0) || rin_b);
    pop_b  = (qb.size() > 0) && rin_b;
    @(posedge clk);
    if (flush_a) qa.delete();
    else begin
      if (pop_a) void'(qa.pop_front());
      if (push_a) qa.push_back(data_a);
    end
    if (flush_b) qb.delete();
    else begin
      if (pop_b) void'(qb.pop_front());
      if (push_b) qb.push_back(data_b);
    end
    if (qa.size() > 0) last_a = qa[0];
    if (qb.size() > 0) last_b = qb[0];
    m_oor = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_a = 1'b1; valid_b = 1'b1; data_a = '1; data_b = '1;
    rin_a = 1'b1; rin_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (ovalid_a !== 1'b0) begin n_err++; $display("FAIL rst_valid_a got %b want 0", ovalid_a); end
    n_cmp++; if (ready_a !== 1'b0) begin n_err++; $display("FAIL rst_ready_a got %b want 0", ready_a); end
    n_cmp++; if (odata_a !== '0) begin n_err++; $display("FAIL rst_data_a got %h want 0", odata_a); end
    n_cmp++; if (occ_a !== 2'd0) begin n_err++; $display("FAIL rst_occ_a got %0d want 0", occ_a); end
    n_cmp++; if (ready_b !== 1'b0) begin n_err++; $display("FAIL rst_ready_b got %b want 0", ready_b); end
    n_cmp++; if (odata_b !== '0) begin n_err++; $display("FAIL rst_data_b got %h want 0", odata_b); end
    valid_a = 1'b0; valid_b = 1'b0; data_a = '0; data_b = '0;
    rst_n = 1'b1;
    reset_model();
    #1;
    n_cmp++; if (ready_a !== 1'b0) begin n_err++; $display("FAIL rel_ready_a_pre got %b want 0", ready_a); end
    n_cmp++; if (ready_b !== 1'b0) begin n_err++; $display("FAIL rel_ready_b_pre got %b want 0", ready_b); end
    tick();
    n_cmp++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL rel_ready_a got %b want 1", ready_a); end
    n_cmp++; if (ready_b !== 1'b1) begin n_err++; $display("FAIL rel_ready_b got %b want 1", ready_b); end
  endtask

  task automatic test_streaming();
    rin_a = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      data_a = beat(n); valid_a = 1'b1;
      tick();
      n_cmp++; if (odata_a !== beat(n)) begin n_err++; $display("FAIL stream_data%0d got %h want %h", n, odata_a, beat(n)); end
      n_cmp++; if (occ_a !== 2'd1 || ovalid_a !== 1'b1) begin n_err++; $display("FAIL stream_occ%0d got %0d/%b want 1/1", n, occ_a, ovalid_a); end
    end
    valid_a = 1'b0; data_a = '1;
    tick();
    n_cmp++; if (ovalid_a !== 1'b0) begin n_err++; $display("FAIL bubble_valid got %b want 0", ovalid_a); end
    n_cmp++; if (odata_a[95:64] !== 32'h0) begin n_err++; $display("FAIL bubble_ctrl got %h want 0", odata_a[95:64]); end
    n_cmp++; if (odata_a[31:0] !== 32'h800 || odata_a[63:32] !== 32'h801 || odata_a[127:96] !== 32'h803) begin
      n_err++; $display("FAIL bubble_hold got %h want 00000803_00000000_00000801_00000800", odata_a); end
  endtask

  task automatic test_backpressure();
    rin_a = 1'b0;
    valid_a = 1'b1; data_a = beat(10); tick();
    data_a = beat(11); tick();
    n_cmp++; if (occ_a !== 2'd2) begin n_err++; $display("FAIL bp_occ2 got %0d want 2", occ_a); end
    n_cmp++; if (ready_a !== 1'b0) begin n_err++; $display("FAIL bp_ready got %b want 0", ready_a); end
    n_cmp++; if (odata_a !== beat(10)) begin n_err++; $display("FAIL bp_head_a got %h want %h", odata_a, beat(10)); end
    data_a = beat(12); tick();
    n_cmp++; if (occ_a !== 2'd2 || odata_a !== beat(10)) begin n_err++; $display("FAIL bp_hold got %0d/%h want 2/%h", occ_a, odata_a, beat(10)); end
    rin_a = 1'b1; tick();
    n_cmp++; if (odata_a !== beat(11) || occ_a !== 2'd1) begin n_err++; $display("FAIL bp_pop_b got %h/%0d want %h/1", odata_a, occ_a, beat(11)); end
    tick();
    n_cmp++; if (odata_a !== beat(12) || occ_a !== 2'd1) begin n_err++; $display("FAIL bp_pop_c got %h/%0d want %h/1", odata_a, occ_a, beat(12)); end
    valid_a = 1'b0; tick();
    n_cmp++; if (ovalid_a !== 1'b0 || occ_a !== 2'd0) begin n_err++; $display("FAIL bp_drain got %b/%0d want 0/0", ovalid_a, occ_a); end
  endtask

  task automatic test_flush();
    rin_a = 1'b0; valid_a = 1'b1;
    data_a = beat(20); tick();
    data_a = beat(21); tick();
    data_a = beat(22); flush_a = 1'b1; tick();
    flush_a = 1'b0; valid_a = 1'b0;
    n_cmp++; if (ovalid_a !== 1'b0 || occ_a !== 2'd0) begin n_err++; $display("FAIL flush_state got %b/%0d want 0/0", ovalid_a, occ_a); end
    n_cmp++; if (odata_a !== masked(beat(20), 1'b1)) begin n_err++; $display("FAIL flush_data got %h want %h", odata_a, masked(beat(20), 1'b1)); end
    n_cmp++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL flush_ready got %b want 1", ready_a); end
    rin_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (ovalid_a !== 1'b0) begin n_err++; $display("FAIL flush_noreplay%0d got %b want 0", i, ovalid_a); end
    end
  endtask

  task automatic test_skid0();
    rin_b = 1'b0; valid_b = 1'b1; data_b = beat(30);
    tick();
    n_cmp++; if (ovalid_b !== 1'b1 || odata_b !== beat(30)) begin n_err++; $display("FAIL s0_head got %b/%h want 1/%h", ovalid_b, odata_b, beat(30)); end
    n_cmp++; if (ready_b !== 1'b0) begin n_err++; $display("FAIL s0_stall_ready got %b want 0", ready_b); end
    data_b = beat(31); rin_b = 1'b1;
    #1;
    n_cmp++; if (ready_b !== 1'b1) begin n_err++; $display("FAIL s0_comb_ready got %b want 1", ready_b); end
    tick();
    n_cmp++; if (odata_b !== beat(31) || occ_b !== 2'd1) begin n_err++; $display("FAIL s0_replace got %h/%0d want %h/1", odata_b, occ_b, beat(31)); end
    valid_b = 1'b0; tick();
    n_cmp++; if (ovalid_b !== 1'b0 || odata_b !== masked(beat(31), 1'b1)) begin n_err++; $display("FAIL s0_drain got %b/%h", ovalid_b, odata_b); end
  endtask

  task automatic test_random();
    logic exp_ra, exp_rb;
    for (int i = 0; i < 400; i++) begin
      data_a = {$urandom, $urandom, $urandom, $urandom};
      data_b = {$urandom, $urandom, $urandom, $urandom};
      valid_a = ($urandom_range(0, 9) < 7); valid_b = ($urandom_range(0, 9) < 7);
      rin_a = ($urandom_range(0, 9) < 6);   rin_b = ($urandom_range(0, 9) < 6);
      flush_a = ($urandom_range(0, 19) == 0); flush_b = ($urandom_range(0, 19) == 0);
      #1;
      exp_ra = m_oor && (qa.size() < 2);
      exp_rb = m_oor && ((qb.size() == 0) || rin_b);
      n_cmp++; if (ready_a !== exp_ra) begin n_err++; $display("FAIL rnd_ready_a[%0d] got %b want %b", i, ready_a, exp_ra); end
      n_cmp++; if (ready_b !== exp_rb) begin n_err++; $display("FAIL rnd_ready_b[%0d] got %b want %b", i, ready_b, exp_rb); end
      tick();
      n_cmp++; if (ovalid_a !== (qa.size() > 0) || occ_a !== 2'(qa.size())) begin
        n_err++; $display("FAIL rnd_occ_a[%0d] got %b/%0d want %0d", i, ovalid_a, occ_a, qa.size()); end
      n_cmp++; if (odata_a !== masked(last_a, qa.size() == 0)) begin
        n_err++; $display("FAIL rnd_data_a[%0d] got %h want %h", i, odata_a, masked(last_a, qa.size() == 0)); end
      n_cmp++; if (ovalid_b !== (qb.size() > 0) || occ_b !== 2'(qb.size())) begin
        n_err++; $display("FAIL rnd_occ_b[%0d] got %b/%0d want %0d", i, ovalid_b, occ_b, qb.size()); end
      n_cmp++; if (odata_b !== masked(last_b, qb.size() == 0)) begin
        n_err++; $display("FAIL rnd_data_b[%0d] got %h want %h", i, odata_b, masked(last_b, qb.size() == 0)); end
    end
    valid_a = 1'b0; valid_b = 1'b0; flush_a = 1'b0; flush_b = 1'b0;
  endtask

  task automatic test_midreset();
    rin_a = 1'b0; valid_a = 1'b1;
    data_a = beat(40); tick();
    data_a = beat(41); tick();
    valid_a = 1'b0;
    n_cmp++; if (occ_a !== 2'd2) begin n_err++; $display("FAIL mr_pre_occ got %0d want 2", occ_a); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (ovalid_a !== 1'b0 || occ_a !== 2'd0) begin n_err++; $display("FAIL mr_async got %b/%0d want 0/0", ovalid_a, occ_a); end
    n_cmp++; if (odata_a !== '0 || ready_a !== 1'b0) begin n_err++; $display("FAIL mr_clear got %h/%b want 0/0", odata_a, ready_a); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    reset_model();
    tick();
    n_cmp++; if (ready_a !== 1'b1 || ovalid_a !== 1'b0) begin n_err++; $display("FAIL mr_recover got %b/%b want 1/0", ready_a, ovalid_a); end
  endtask

  initial begin
    reset_model();
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_skid0();
    test_random();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
